aes_cipher_core: RTL and testbench

AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

---
 rtl/aes_cipher_core.sv | 203 ++++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes_cipher_core (with helper sub_word)
//  Description : Iterative AES encryption core, one round per clock. Supports
//                128/192/256-bit keys selected at run time by Nk; round keys
//                are read live from an externally expanded key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================

// Four parallel AES S-box lookups on a 32-bit word.
module sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] base;
        base = 11'd2047 - {a, 3'b000};
        return SBOX[base -: 8];
    endfunction

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
        end
    endgenerate

endmodule

module aes_cipher_core (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    Nk,
    input  logic [1919:0] w,
    input  logic          key_valid,
    input  logic          start,
    input  logic [127:0]  in_block,
    output logic          ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_block,
    output logic          cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_next;
    logic [3:0]   r_nr;
    logic [3:0]   r_round;
    logic [127:0] r_state;

    logic         w_nk_legal;
    logic         w_accept;
    logic         w_reject;
    logic         w_last;
    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_rk;
    logic [127:0] w_round_out;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Round key r is schedule words 4r..4r+3; word 4r becomes column 0,
    // which sits in the top 32 bits of the state.
    function automatic logic [127:0] round_key(input logic [1919:0] ks,
                                               input logic [3:0]    r);
        logic [10:0] base;
        base = {r, 7'b0000000};
        return {ks[base +: 32], ks[base + 11'd32 +: 32],
                ks[base + 11'd64 +: 32], ks[base + 11'd96 +: 32]};
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[120 - 32*c - 8*r +: 8] = s[120 - 32*((c + r) % 4) - 8*r +: 8];
            end
        end
        return o;
    endfunction

    // Each column is multiplied by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02}.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[120 - 32*c +: 8];
            a1 = s[112 - 32*c +: 8];
            a2 = s[104 - 32*c +: 8];
            a3 = s[96  - 32*c +: 8];
            o[120 - 32*c +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[112 - 32*c +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[104 - 32*c +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[96  - 32*c +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign w_nk_legal = (Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8);
    assign w_accept   = (r_fsm == ST_IDLE) && start && key_valid && w_nk_legal;
    assign w_reject   = (r_fsm == ST_IDLE) && start && key_valid && !w_nk_legal;
    assign w_last     = (r_round == r_nr);

    // SubBytes: one S-box word per state column.
    generate
        for (genvar c = 0; c < 4; c++) begin : g_sub_col
            sub_word u_sub_word (
                .word_in  (r_state[96 - 32*c +: 32]),
                .word_out (w_sub[96 - 32*c +: 32])
            );
        end
    endgenerate

    assign w_shift     = shift_rows(w_sub);
    assign w_mix       = mix_columns(w_shift);
    assign w_rk        = round_key(w, r_round);
    // The final round omits MixColumns.
    assign w_round_out = (w_last ? w_shift : w_mix) ^ w_rk;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:  if (w_accept) w_fsm_next = ST_ROUND;
            ST_ROUND: if (w_last)   w_fsm_next = ST_DONE;
            ST_DONE:  if (out_ready) w_fsm_next = ST_IDLE;
            default:  w_fsm_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        ready     = (r_fsm == ST_IDLE) && key_valid;
        out_valid = (r_fsm == ST_DONE);
    end

    // Datapath: initial AddRoundKey on accept, one full round per ROUND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nr      <= 4'd0;
            r_round   <= 4'd0;
            r_state   <= '0;
            out_block <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= w_reject;
            if (w_accept) begin
                r_nr    <= Nk + 4'd6;
                r_state <= in_block ^ round_key(w, 4'd0);
                r_round <= 4'd1;
            end else if (r_fsm == ST_ROUND) begin
                r_state <= w_round_out;
                if (w_last) begin
                    out_block <= w_round_out;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_cipher_core
//  Description : Scoreboard bench for aes_cipher_core using the FIPS-197
//                example vectors for all three key lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_core;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    Nk;
    logic [1919:0] w;
    logic          key_valid;
    logic          start;
    logic [127:0]  in_block;
    logic          ready;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_block;
    logic          cfg_err;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] blk;
        int           c0;
        int           nr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;

    aes_cipher_core dut (
        .clk       (clk),
        .rst       (rst),
        .Nk        (Nk),
        .w         (w),
        .key_valid (key_valid),
        .start     (start),
        .in_block  (in_block),
        .ready     (ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .cfg_err   (cfg_err)
    );

    // Edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising out_valid is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %h with no block pending", out_block);
            end else begin
                e = sb.pop_front();
                check("out_block", out_block, e.blk);
                check("latency", 128'(cyc - e.c0), 128'(e.nr));
            end
        end
        prev_ov <= out_valid;
    end

    // ---------------- reference key schedule (FIPS-197 KeyExpansion) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from the field inverse and affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  r = 8'h01;
        logic [7:0]  sq;
        logic [15:0] d;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        if (a == 8'h00) r = 8'h00;
        d = {r, r};
        return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // Key bytes are 00,01,02,... ; returns the packed schedule for Nk words.
    function automatic logic [1919:0] key_sched(input int nk);
        logic [31:0]   wd [0:59];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] o;
        for (int i = 0; i < 60; i++) wd[i] = 32'h0;
        for (int i = 0; i < nk; i++)
            wd[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        for (int i = nk; i < 4*(nk + 7); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        o = '0;
        for (int i = 0; i < 60; i++) o[32*i +: 32] = wd[i];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic setup(input int nk);
        Nk        = 4'(nk);
        w         = key_sched(nk);
        in_block  = PT;
        key_valid = 1'b1;
    endtask

    task automatic issue(input logic [127:0] exp, input int nr, input bit push);
        exp_t e;
        check("ready_before_start", 128'(ready), 128'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.blk = exp;
            e.c0  = cyc;
            e.nr  = nr;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        check("done_in_time", 128'(out_valid), 128'd1);
    endtask

    task automatic handshake(input logic [127:0] exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_hs", 128'(out_valid), 128'd0);
        check("block_kept_after_hs", out_block, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; key_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        Nk = 4'd4; w = '0; in_block = PT;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_block", out_block, 128'd0);
        check("rst_cfg_err", 128'(cfg_err), 128'd0);
        check("rst_ready_nokey", 128'(ready), 128'd0);
        rst = 1'b0;

        // start while key_valid is low is ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("nokey_cfg_err", 128'(cfg_err), 128'd0);
        check("nokey_ready", 128'(ready), 128'd0);
        @(posedge clk);
        #1;
        check("nokey_no_valid", 128'(out_valid), 128'd0);

        // illegal Nk
        Nk = 4'd5; key_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("badnk_cfg_err", 128'(cfg_err), 128'd1);
        check("badnk_ready", 128'(ready), 128'd1);
        check("badnk_no_valid", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("badnk_pulse_width", 128'(cfg_err), 128'd0);
        check("badnk_still_idle", 128'(ready), 128'd1);

        // AES-128
        setup(4);
        issue(CT128, 10, 1);
        wait_done();
        handshake(CT128);

        // AES-192, disturb Nk/in_block and pulse start while busy
        setup(6);
        issue(CT192, 12, 1);
        Nk = 4'd5; in_block = '1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_cfg_err", 128'(cfg_err), 128'd0);
        check("busy_ready", 128'(ready), 128'd0);
        wait_done();
        // back-pressure with start pulses
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            @(negedge clk);
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_block", out_block, CT192);
        end
        start = 1'b0;
        handshake(CT192);

        // immediate turnaround
        setup(4);
        issue(CT128, 10, 1);
        wait_done();
        handshake(CT128);

        // AES-256 aborted by reset at round 5
        setup(8);
        issue(CT256, 14, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_out_block", out_block, 128'd0);
        check("abort_ready", 128'(ready), 128'd1);

        // AES-256 full run after abort
        issue(CT256, 14, 1);
        wait_done();
        handshake(CT256);

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
